// File: rtl/uart_tx_sched_pkg.sv
// Shared defaults and FSM encoding for the UART transmit scheduler.
package uart_tx_sched_pkg;
  localparam int UART_FIFO_DEPTH_LOG2 = 4;
  localparam int UART_GAP_DEFAULT     = 0;
  localparam int UART_BUSY_TMO        = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAITB = 3'd2,
    S_WAITE = 3'd3,
    S_GAP   = 3'd4
  } sched_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with extra-MSB pointers; flush zeroes both pointers and beats a same-cycle push.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [7:0]            data_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [7:0]            data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_q, rd_q, wr_d, rd_d;
  logic                do_push, do_pop;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_d = wr_q + (DEPTH_LOG2+1)'(do_push);
    rd_d = rd_q + (DEPTH_LOG2+1)'(do_pop);
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= data_i;
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: queues CPU bytes and hands them one at a time to uart_tx
// using a start/busy/end handshake with busy timeout and optional inter-byte gap.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int GAP_CYCLES = UART_GAP_DEFAULT,
  parameter int BUSY_TMO   = UART_BUSY_TMO
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [7:0]          wr_data_i,
  input  logic                flush_i,
  input  logic                ovf_clr_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic                overflow_o,
  output logic                stall_o,
  output logic                tx_start_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_busy_i,
  input  logic                tx_end_i
);
  localparam logic [7:0]   GAP_LOAD  = 8'(GAP_CYCLES - 1);
  localparam sched_state_e DONE_ST   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  sched_state_e state_q;
  logic [7:0]   tmo_q, gap_q, tx_data_q, fifo_head;
  logic [7:0]   tmo_inc;
  logic         tx_start_q, overflow_q, stall_q;
  logic         fifo_full, fifo_empty;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_en_i),
    .data_i  (wr_data_i),
    .pop_i   (state_q == S_ISSUE),
    .flush_i (flush_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign tmo_inc = tmo_q + 8'd1;

  // The timeout counter tracks cycles since tx_start (0 in the ISSUE cycle), so
  // stall becomes visible exactly BUSY_TMO cycles after the start pulse.
  // tx_start/tx_data are registered: they are loaded on the edge into ISSUE so
  // the pulse coincides with the ISSUE cycle in which the head is popped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (wr_en_i && fifo_full && !flush_i) overflow_q <= 1'b1;
      else if (ovf_clr_i)                   overflow_q <= 1'b0;
      if (ovf_clr_i) stall_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty && !flush_i) begin
            state_q    <= S_ISSUE;
            tx_start_q <= 1'b1;
            tx_data_q  <= fifo_head;
            tmo_q      <= '0;
          end
        end
        S_ISSUE: begin
          tmo_q   <= tmo_inc;
          state_q <= S_WAITB;
        end
        S_WAITB: begin
          if (tx_end_i) begin
            state_q <= DONE_ST;
            gap_q   <= GAP_LOAD;
          end else if (tx_busy_i) begin
            state_q <= S_WAITE;
          end else if (tmo_inc == 8'(BUSY_TMO)) begin
            stall_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        S_WAITE: begin
          if (tx_end_i) begin
            state_q <= DONE_ST;
            gap_q   <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) state_q <= S_IDLE;
          else               gap_q   <= gap_q - 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;
  assign overflow_o = overflow_q;
  assign stall_o    = stall_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx model (GAP_CYCLES=3).
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_en = 1'b0, flush = 1'b0, ovf_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_busy, tx_end;
  logic       full, empty, overflow, stall, tx_start;
  logic [4:0] level;
  logic [7:0] tx_data;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int mode = 0;  // 0 normal, 1 hold busy, 2 mute (never busy)
  int mcnt;

  int         st_cyc[$], end_cyc[$];
  logic [7:0] st_dat[$];
  logic [7:0] held;
  bit         in_xfer = 0;
  int         unstable = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sched #(.GAP_CYCLES(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .flush_i(flush), .ovf_clr_i(ovf_clr), .full_o(full), .empty_o(empty),
    .level_o(level), .overflow_o(overflow), .stall_o(stall),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy), .tx_end_i(tx_end)
  );

  // uart_tx model: busy the cycle after start, tx_end pulse 4 cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0; tx_end <= 1'b0; mcnt <= 0;
    end else begin
      tx_end <= 1'b0;
      if (tx_start && mode != 2) begin
        tx_busy <= 1'b1; mcnt <= 3;
      end else if (tx_busy && mode == 0) begin
        if (mcnt == 0) begin tx_busy <= 1'b0; tx_end <= 1'b1; end
        else mcnt <= mcnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) in_xfer = 0;
    else begin
      if (tx_start) begin
        st_cyc.push_back(cyc); st_dat.push_back(tx_data); held = tx_data; in_xfer = 1;
      end else if (in_xfer && tx_data !== held) unstable++;
      if (tx_end) begin end_cyc.push_back(cyc); in_xfer = 0; end
    end
  end

  task automatic nedge();
    @(negedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xfers(input int n, input int budget, input string tag);
    int k = 0;
    while (end_cyc.size() < n && k < budget) begin nedge(); k++; end
    chk(tag, end_cyc.size(), n);
  endtask

  task automatic wait_state(input sched_state_e s, input int budget, input string tag);
    int k = 0;
    while (dut.state_q != s && k < budget) begin nedge(); k++; end
    chk(tag, dut.state_q, s);
  endtask

  task automatic clr_logs();
    st_cyc.delete(); end_cyc.delete(); st_dat.delete();
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; nedge(); wr_en = 1'b0;
  endtask

  initial begin
    logic [7:0] hello [5];
    int c0, s, k;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    // reset values
    repeat (5) nedge();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    repeat (2) nedge();

    // single byte
    clr_logs(); mode = 0;
    c0 = cyc;
    push(8'h41);
    wait_xfers(1, 50, "single_done");
    chk("single_lat", st_cyc[0], c0 + 2);
    chk("single_data", st_dat[0], 8'h41);
    chk("single_starts", st_cyc.size(), 1);
    repeat (6) nedge();
    chk("single_idle", dut.state_q, S_IDLE);
    chk("single_empty", empty, 1);

    // burst "Hello" with a 3-cycle gap
    clr_logs();
    c0 = cyc;
    for (int i = 0; i < 5; i++) push(hello[i]);
    wait_xfers(5, 300, "burst_done");
    chk("burst_lat", st_cyc[0], c0 + 2);
    for (int i = 0; i < 5; i++) chk($sformatf("burst_data%0d", i), st_dat[i], hello[i]);
    for (int i = 1; i < 5; i++) chk($sformatf("burst_gap%0d", i), st_cyc[i] - end_cyc[i-1], 5);
    chk("burst_stable", unstable, 0);
    repeat (6) nedge();

    // overflow: byte 0 held by uart_tx, 16 more fill the FIFO
    clr_logs(); mode = 1;
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
    nedge();
    chk("ovf_full", full, 1);
    chk("ovf_level16", level, 16);
    chk("ovf_not_yet", overflow, 0);
    chk("ovf_first", st_dat[0], 8'h80);
    push(8'hEE);
    chk("ovf_set", overflow, 1);
    chk("ovf_level_kept", level, 16);
    ovf_clr = 1'b1; nedge(); ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    wr_en = 1'b1; ovf_clr = 1'b1; nedge(); wr_en = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1; nedge(); ovf_clr = 1'b0;
    chk("ovf_clr2", overflow, 0);
    flush = 1'b1; nedge(); flush = 1'b0;
    chk("ovf_flush_level", level, 0);
    mode = 0;
    wait_xfers(1, 50, "ovf_drain");
    repeat (8) nedge();

    // flush while the current byte is in flight
    clr_logs(); mode = 1;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    wait_state(S_WAITE, 20, "flush_waite");
    flush = 1'b1; nedge(); flush = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    mode = 0;
    wait_xfers(1, 50, "flush_end");
    repeat (15) nedge();
    chk("flush_starts", st_cyc.size(), 1);
    chk("flush_data", st_dat[0], 8'hA0);
    chk("flush_idle", dut.state_q, S_IDLE);

    // busy timeout
    clr_logs(); mode = 2;
    push(8'hB0); push(8'hB1);
    k = 0;
    while (st_cyc.size() == 0 && k < 30) begin nedge(); k++; end
    chk("stall_start", st_cyc.size(), 1);
    s = st_cyc[0];
    while (cyc < s + 6) nedge();
    chk("stall_early", stall, 0);
    nedge();
    chk("stall_set", stall, 1);
    chk("stall_idle", dut.state_q, S_IDLE);
    mode = 0;
    wait_xfers(1, 50, "stall_next_end");
    chk("stall_next_lat", st_cyc[1], s + 8);
    chk("stall_next_data", st_dat[1], 8'hB1);
    chk("stall_sticky", stall, 1);
    ovf_clr = 1'b1; nedge(); ovf_clr = 1'b0;
    chk("stall_clr", stall, 0);
    repeat (6) nedge();

    // asynchronous reset while in WAITE
    clr_logs(); mode = 1;
    push(8'hC5); push(8'hC6);
    wait_state(S_WAITE, 20, "arst_waite");
    chk("arst_pre_data", tx_data, 8'hC5);
    rst_n = 1'b0; #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_tx_data", tx_data, 8'h00);
    chk("arst_tx_start", tx_start, 0);
    chk("arst_state", dut.state_q, S_IDLE);
    nedge(); rst_n = 1'b1; nedge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
